// File: rtl/sr_shift_out_pkg.sv
// Shared types and defaults for the serial shift-out path.
// The controller uses the same word-size defaults.
package sr_shift_out_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } sr_state_t;

  localparam int DEFAULT_WIDTH   = 8;
  localparam int DEFAULT_CLK_DIV = 2;

endpackage

// File: rtl/sr_shift_out_phase_div.sv
// Phase tick generator: o_tick marks the last cycle of each CLK_DIV-cycle phase.
// i_clear restarts the phase so every state entry gets a full phase.
module sr_phase_div #(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_tick;

  assign w_tick = i_en && (r_cnt == LAST);
  assign o_tick = w_tick;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (w_tick) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sr_shift_out.sv
// Parallel-in serial-out driver for a 74HC595-style chain, with rclk latch pulse.
// Handshake: i_load / i_latch are single-cycle requests honoured only while o_busy=0.
module sr_shift_out
  import sr_shift_out_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int CLK_DIV   = DEFAULT_CLK_DIV,
  parameter int MSB_FIRST = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_load,
  input  logic             i_latch,
  output logic             o_busy,
  output logic             o_sdata,
  output logic             o_sclk,
  output logic             o_rclk
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  sr_state_t        r_state;
  sr_state_t        w_state_nxt;
  logic [BW-1:0]    r_bit_cnt;
  logic [BW-1:0]    w_bit_cnt_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [WIDTH-1:0] w_shifted;
  logic             r_busy;
  logic             r_sdata;
  logic             r_sclk;
  logic             r_rclk;
  logic             w_busy_nxt;
  logic             w_sdata_nxt;
  logic             w_sclk_nxt;
  logic             w_rclk_nxt;
  logic             w_tick;
  logic             w_clear;
  logic             w_div_en;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  // Shift toward the end that is sent first so the next bit is always at that end.
  assign w_shifted = (MSB_FIRST != 0) ? {r_shreg[WIDTH-2:0], 1'b0}
                                      : {1'b0, r_shreg[WIDTH-1:1]};

  assign w_clear  = (w_state_nxt != r_state);
  assign w_div_en = (r_state != IDLE);

  sr_phase_div #(
    .CLK_DIV (CLK_DIV)
  ) u_phase_div (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (w_clear),
    .i_en    (w_div_en),
    .o_tick  (w_tick)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_busy    <= 1'b0;
      r_sdata   <= 1'b0;
      r_sclk    <= 1'b0;
      r_rclk    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shreg   <= w_shreg_nxt;
      r_busy    <= w_busy_nxt;
      r_sdata   <= w_sdata_nxt;
      r_sclk    <= w_sclk_nxt;
      r_rclk    <= w_rclk_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shreg_nxt   = r_shreg;
    w_busy_nxt    = r_busy;
    w_sdata_nxt   = r_sdata;
    w_sclk_nxt    = r_sclk;
    w_rclk_nxt    = r_rclk;
    case (r_state)
      IDLE: begin
        if (i_latch) begin
          // Latch wins over a simultaneous load; the load is dropped.
          w_state_nxt   = LATCH;
          w_bit_cnt_nxt = '0;
          w_busy_nxt    = 1'b1;
          w_rclk_nxt    = 1'b1;
          w_sclk_nxt    = 1'b0;
          w_sdata_nxt   = 1'b0;
        end else if (i_load) begin
          w_state_nxt   = SHIFT_LO;
          w_bit_cnt_nxt = '0;
          w_shreg_nxt   = i_data;
          w_busy_nxt    = 1'b1;
          w_sclk_nxt    = 1'b0;
          w_sdata_nxt   = first_bit(i_data);
        end
      end
      SHIFT_LO: begin
        if (w_tick) begin
          w_state_nxt = SHIFT_HI;
          w_sclk_nxt  = 1'b1;
        end
      end
      SHIFT_HI: begin
        if (w_tick) begin
          w_sclk_nxt = 1'b0;
          if (r_bit_cnt == LAST_BIT) begin
            w_state_nxt   = IDLE;
            w_bit_cnt_nxt = '0;
            w_shreg_nxt   = '0;
            w_sdata_nxt   = 1'b0;
            w_busy_nxt    = 1'b0;
          end else begin
            w_state_nxt   = SHIFT_LO;
            w_bit_cnt_nxt = r_bit_cnt + BW'(1);
            w_shreg_nxt   = w_shifted;
            w_sdata_nxt   = first_bit(w_shifted);
          end
        end
      end
      LATCH: begin
        // Two divider phases make up the 2*CLK_DIV-cycle rclk pulse.
        if (w_tick) begin
          if (r_bit_cnt == BW'(1)) begin
            w_state_nxt   = IDLE;
            w_bit_cnt_nxt = '0;
            w_rclk_nxt    = 1'b0;
            w_busy_nxt    = 1'b0;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BW'(1);
          end
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_bit_cnt_nxt = '0;
        w_shreg_nxt   = '0;
        w_busy_nxt    = 1'b0;
        w_sdata_nxt   = 1'b0;
        w_sclk_nxt    = 1'b0;
        w_rclk_nxt    = 1'b0;
      end
    endcase
  end

  assign o_busy  = r_busy;
  assign o_sdata = r_sdata;
  assign o_sclk  = r_sclk;
  assign o_rclk  = r_rclk;

endmodule

// File: tb/tb_sr_shift_out.sv
// Bench for sr_shift_out: MSB-first and LSB-first instances share one stimulus;
// serial bits are checked against expected queues at every sclk rise.
module tb_sr_shift_out;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_load = 1'b0;
  logic       i_latch = 1'b0;
  logic       o_busy, o_sdata, o_sclk, o_rclk;
  logic       l_busy, l_sdata, l_sclk, l_rclk;

  int n_tests = 0;
  int n_fail  = 0;
  int rise_cnt = 0;
  logic [0:0] exp_q[$];
  logic [0:0] exp_lsb_q[$];

  typedef struct {
    string      name;
    logic       load;
    logic       latch;
    logic [7:0] data;
    int         exp_busy;
    int         exp_rises;
    int         exp_rclk;
  } vec_t;

  vec_t vecs[8];

  sr_shift_out #(.WIDTH(8), .CLK_DIV(2), .MSB_FIRST(1)) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_load(i_load), .i_latch(i_latch),
    .o_busy(o_busy), .o_sdata(o_sdata), .o_sclk(o_sclk), .o_rclk(o_rclk)
  );

  sr_shift_out #(.WIDTH(8), .CLK_DIV(2), .MSB_FIRST(0)) u_dut_lsb (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_load(i_load), .i_latch(i_latch),
    .o_busy(l_busy), .o_sdata(l_sdata), .o_sclk(l_sclk), .o_rclk(l_rclk)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(d[7-i]);
      exp_lsb_q.push_back(d[i]);
    end
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_busy"},  o_busy,  0);
    check({nm, "_sdata"}, o_sdata, 0);
    check({nm, "_sclk"},  o_sclk,  0);
    check({nm, "_rclk"},  o_rclk,  0);
    check({nm, "_lsb_outs"}, {28'd0, l_busy, l_sdata, l_sclk, l_rclk}, 0);
  endtask

  task automatic wait_idle(input string nm);
    for (int k = 0; k < 100 && o_busy; k++) tick();
    check({nm, "_idle_wait"}, o_busy, 0);
  endtask

  // Scoreboard monitor: pop one expected bit per rising sclk on each instance.
  initial begin
    logic prev_m;
    logic prev_l;
    logic [0:0] e;
    prev_m = 1'b0;
    prev_l = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      if (o_sclk && !prev_m) begin
        rise_cnt++;
        if (exp_q.size() == 0) check("sdata_msb_unexpected_rise", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("sdata_msb", o_sdata, e);
        end
      end
      if (l_sclk && !prev_l) begin
        if (exp_lsb_q.size() == 0) check("sdata_lsb_unexpected_rise", 1, 0);
        else begin
          e = exp_lsb_q.pop_front();
          check("sdata_lsb", l_sdata, e);
        end
      end
      prev_m = o_sclk;
      prev_l = l_sclk;
    end
  end

  task automatic run_vector(input vec_t v);
    int busy_n;
    int rclk_n;
    int r0;
    wait_idle(v.name);
    i_data  = v.data;
    i_load  = v.load;
    i_latch = v.latch;
    if (v.load && !v.latch) push_word(v.data);
    r0 = rise_cnt;
    tick();
    i_load  = 1'b0;
    i_latch = 1'b0;
    busy_n = 0;
    rclk_n = 0;
    for (int k = 0; k < 200 && o_busy; k++) begin
      busy_n++;
      if (o_rclk) rclk_n++;
      tick();
    end
    check({v.name, "_busy_cycles"}, busy_n, v.exp_busy);
    check({v.name, "_rclk_cycles"}, rclk_n, v.exp_rclk);
    check({v.name, "_sclk_rises"}, rise_cnt - r0, v.exp_rises);
    check({v.name, "_bits_left"}, exp_q.size() + exp_lsb_q.size(), 0);
    check_all_zero({v.name, "_after"});
  endtask

  initial begin
    int busy_n;
    int rclk_n;
    int r0;
    vec_t v;

    vecs[0] = '{"a5",        1'b1, 1'b0, 8'hA5, 32, 8, 0};
    vecs[1] = '{"3c",        1'b1, 1'b0, 8'h3C, 32, 8, 0};
    vecs[2] = '{"latch",     1'b0, 1'b1, 8'h00,  4, 0, 4};
    vecs[3] = '{"ld_and_lt", 1'b1, 1'b1, 8'hC3,  4, 0, 4};
    vecs[4] = '{"81",        1'b1, 1'b0, 8'h81, 32, 8, 0};
    vecs[5] = '{"00",        1'b1, 1'b0, 8'h00, 32, 8, 0};
    vecs[6] = '{"ff",        1'b1, 1'b0, 8'hFF, 32, 8, 0};
    vecs[7] = '{"5a",        1'b1, 1'b0, 8'h5A, 32, 8, 0};

    i_rst = 1'b1;
    repeat (3) tick();
    i_rst = 1'b0;
    check_all_zero("reset");
    tick();
    check_all_zero("idle_no_req");

    for (int i = 0; i < 7; i++) run_vector(vecs[i]);

    // Requests while shifting are dropped; busy seen two cycles after load.
    wait_idle("ignore");
    i_data = 8'hFF;
    i_load = 1'b1;
    push_word(8'hFF);
    r0 = rise_cnt;
    tick();
    i_load = 1'b0;
    check("busy_after_load_1", o_busy, 1);
    busy_n = 0;
    rclk_n = 0;
    for (int k = 0; k < 40; k++) begin
      if (o_busy) busy_n++;
      if (o_rclk) rclk_n++;
      if (k == 1) check("busy_after_load_2", o_busy, 1);
      if (k == 9) begin
        i_data  = 8'h00;
        i_load  = 1'b1;
        i_latch = 1'b1;
      end
      if (k == 10) begin
        i_load  = 1'b0;
        i_latch = 1'b0;
      end
      if (k == 31) check("ignore_busy_last", o_busy, 1);
      if (k == 32) check("ignore_busy_fall", o_busy, 0);
      tick();
    end
    check("ignore_busy_cycles", busy_n, 32);
    check("ignore_rclk_cycles", rclk_n, 0);
    check("ignore_sclk_rises", rise_cnt - r0, 8);
    check("ignore_bits_left", exp_q.size() + exp_lsb_q.size(), 0);

    // Reset in the middle of a word abandons it.
    wait_idle("rst_mid");
    i_data = 8'h33;
    i_load = 1'b1;
    push_word(8'h33);
    tick();
    i_load = 1'b0;
    repeat (12) tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check_all_zero("rst_mid");
    exp_q.delete();
    exp_lsb_q.delete();
    tick();
    check_all_zero("rst_mid_hold");
    v = vecs[7];
    run_vector(v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
